// File: rtl/mat_pkg.sv
// Shared types, ASCII constants and character helpers for the streaming
// matrix multiplier and its result formatter.
package mat_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_MAC,
        ST_EMIT,
        ST_DONE
    } state_e;

    typedef enum logic [3:0] {
        PH_IDLE,
        PH_HDR,
        PH_HCR,
        PH_HLF,
        PH_LBR,
        PH_LSP,
        PH_DIG,
        PH_COMMA,
        PH_CSP,
        PH_RSP,
        PH_RBR,
        PH_RCR,
        PH_RLF,
        PH_ECR,
        PH_ELF
    } phase_e;

    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_LBR   = 8'h5B;
    localparam logic [7:0] CH_RBR   = 8'h5D;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_SPACE = 8'h20;

    localparam int                    HDR_LEN = 14;
    localparam logic [8*HDR_LEN-1:0]  HDR_STR = "The result is:";

    // Character idx of the header, counting from the leftmost character.
    function automatic logic [7:0] hdr_char(input logic [3:0] idx);
        return HDR_STR[8*(HDR_LEN-1-int'(idx)) +: 8];
    endfunction

    // Returns {is_hex, nibble}.
    function automatic logic [4:0] hex2nib(input logic [7:0] ch);
        logic [4:0] r;
        r = 5'h00;
        if (ch >= 8'h30 && ch <= 8'h39)      r = {1'b1, 4'(ch - 8'h30)};
        else if (ch >= 8'h41 && ch <= 8'h46) r = {1'b1, 4'(ch - 8'h37)};
        else if (ch >= 8'h61 && ch <= 8'h66) r = {1'b1, 4'(ch - 8'h57)};
        return r;
    endfunction

    function automatic logic [7:0] nib2hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic int acc_width(input int n, input int ew);
        return 2*ew + $clog2(n);
    endfunction

endpackage

// File: rtl/mat_ascii_fmt.sv
// EMIT sequencer: walks the result register file and prints it as ASCII text
// over a valid/ready byte stream.
module mat_ascii_fmt
    import mat_pkg::*;
#(
    parameter int N    = 4,
    parameter int ODIG = 4,
    parameter int ACCW = 18
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_emit,
    input  logic [ACCW-1:0] c_i [N][N],
    output logic            out_valid,
    output logic [7:0]      out_byte,
    input  logic            out_ready,
    output logic            emit_done,
    output phase_e          dbg_phase
);
    localparam int              IW       = $clog2(N);
    localparam int              OW       = $clog2(ODIG + 1);
    localparam logic [IW-1:0]   N_M1     = IW'(N - 1);
    localparam logic [OW-1:0]   O_M1     = OW'(ODIG - 1);
    localparam logic [3:0]      HDR_LAST = 4'(HDR_LEN - 1);

    phase_e            ph_q, ph_d;
    logic [3:0]        idx_q, idx_d;
    logic [IW-1:0]     row_q, row_d, col_q, col_d;
    logic [OW-1:0]     dig_q, dig_d;
    logic [4*ODIG-1:0] elem_low;
    logic [3:0]        nib;
    logic              xfer;

    // out_byte is a decode of registered counters, so it cannot change while stalled.
    assign out_valid = (ph_q != PH_IDLE);
    assign xfer      = out_valid & out_ready;
    assign elem_low  = (4*ODIG)'(c_i[row_q][col_q]);
    assign nib       = elem_low[4*(ODIG-1-int'(dig_q)) +: 4];
    assign dbg_phase = ph_q;

    always_comb begin
        ph_d      = ph_q;
        idx_d     = idx_q;
        row_d     = row_q;
        col_d     = col_q;
        dig_d     = dig_q;
        out_byte  = 8'h00;
        emit_done = 1'b0;
        unique case (ph_q)
            PH_IDLE: if (start_emit) begin
                ph_d  = PH_HDR;
                idx_d = '0;
                row_d = '0;
                col_d = '0;
                dig_d = '0;
            end
            PH_HDR: begin
                out_byte = hdr_char(idx_q);
                if (xfer) begin
                    if (idx_q == HDR_LAST) ph_d = PH_HCR;
                    else                   idx_d = idx_q + 4'd1;
                end
            end
            PH_HCR:   begin out_byte = CH_CR;    if (xfer) ph_d = PH_HLF; end
            PH_HLF:   begin out_byte = CH_LF;    if (xfer) ph_d = PH_LBR; end
            PH_LBR:   begin out_byte = CH_LBR;   if (xfer) ph_d = PH_LSP; end
            PH_LSP:   begin out_byte = CH_SPACE; if (xfer) ph_d = PH_DIG; end
            PH_DIG: begin
                out_byte = nib2hex(nib);
                if (xfer) begin
                    if (dig_q == O_M1) begin
                        dig_d = '0;
                        ph_d  = (col_q == N_M1) ? PH_RSP : PH_COMMA;
                    end else begin
                        dig_d = dig_q + OW'(1);
                    end
                end
            end
            PH_COMMA: begin out_byte = CH_COMMA; if (xfer) ph_d = PH_CSP; end
            PH_CSP: begin
                out_byte = CH_SPACE;
                if (xfer) begin
                    col_d = col_q + IW'(1);
                    ph_d  = PH_DIG;
                end
            end
            PH_RSP:   begin out_byte = CH_SPACE; if (xfer) ph_d = PH_RBR; end
            PH_RBR:   begin out_byte = CH_RBR;   if (xfer) ph_d = PH_RCR; end
            PH_RCR:   begin out_byte = CH_CR;    if (xfer) ph_d = PH_RLF; end
            PH_RLF: begin
                out_byte = CH_LF;
                if (xfer) begin
                    col_d = '0;
                    if (row_q == N_M1) begin
                        ph_d = PH_ECR;
                    end else begin
                        row_d = row_q + IW'(1);
                        ph_d  = PH_LBR;
                    end
                end
            end
            PH_ECR:   begin out_byte = CH_CR;    if (xfer) ph_d = PH_ELF; end
            PH_ELF: begin
                out_byte = CH_LF;
                if (xfer) begin
                    ph_d      = PH_IDLE;
                    emit_done = 1'b1;
                end
            end
            default: ph_d = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph_q  <= PH_IDLE;
            idx_q <= '0;
            row_q <= '0;
            col_q <= '0;
            dig_q <= '0;
        end else begin
            ph_q  <= ph_d;
            idx_q <= idx_d;
            row_q <= row_d;
            col_q <= col_d;
            dig_q <= dig_d;
        end
    end

endmodule

// File: rtl/mat_mult_stream.sv
// Streaming NxN hex-text matrix multiplier: loads A and B column-major from an
// ASCII byte stream, computes C = A*B one element per cycle, prints C as text.
module mat_mult_stream
    import mat_pkg::*;
#(
    parameter int N      = 4,
    parameter int DIGITS = 2,
    parameter int ODIG   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_byte,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output state_e     dbg_state,
    output phase_e     dbg_phase
);
    localparam int            EW     = 4*DIGITS;
    localparam int            ACCW   = acc_width(N, EW);
    localparam int            IW     = $clog2(N);
    localparam int            DW     = $clog2(DIGITS + 1);
    localparam logic [IW-1:0] N_M1   = IW'(N - 1);
    localparam logic [DW-1:0] DIG_M1 = DW'(DIGITS - 1);

    state_e          state_q, state_d;
    logic            in_ready_q;
    logic [IW-1:0]   ld_row_q, ld_row_d, ld_col_q, ld_col_d;
    logic [IW-1:0]   mac_r_q, mac_r_d, mac_c_q, mac_c_d;
    logic [DW-1:0]   dig_q, dig_d;
    logic [EW-1:0]   part_q, part_d;
    logic [EW-1:0]   a_q [N][N];
    logic [EW-1:0]   b_q [N][N];
    logic [ACCW-1:0] c_q [N][N];

    logic [4:0]      hex_c;
    logic [EW-1:0]   new_elem;
    logic            in_xfer, store_a, store_b, mac_en, start_emit, emit_done;
    logic [2*EW-1:0] prod [N];
    logic [ACCW-1:0] mac_sum;

    assign hex_c    = hex2nib(in_byte);
    assign new_elem = EW'({part_q, hex_c[3:0]});
    assign in_xfer  = in_valid & in_ready_q;
    assign mac_en   = (state_q == ST_MAC);

    // Loader counters walk row fastest, giving the column-major element order.
    always_comb begin
        state_d    = state_q;
        ld_row_d   = ld_row_q;
        ld_col_d   = ld_col_q;
        mac_r_d    = mac_r_q;
        mac_c_d    = mac_c_q;
        dig_d      = dig_q;
        part_d     = part_q;
        store_a    = 1'b0;
        store_b    = 1'b0;
        start_emit = 1'b0;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD_A;
            ST_LOAD_A, ST_LOAD_B: if (in_xfer && hex_c[4]) begin
                if (dig_q == DIG_M1) begin
                    part_d  = '0;
                    dig_d   = '0;
                    store_a = (state_q == ST_LOAD_A);
                    store_b = (state_q == ST_LOAD_B);
                    if (ld_row_q == N_M1) begin
                        ld_row_d = '0;
                        if (ld_col_q == N_M1) begin
                            ld_col_d = '0;
                            state_d  = (state_q == ST_LOAD_A) ? ST_LOAD_B : ST_MAC;
                        end else begin
                            ld_col_d = ld_col_q + IW'(1);
                        end
                    end else begin
                        ld_row_d = ld_row_q + IW'(1);
                    end
                end else begin
                    part_d = new_elem;
                    dig_d  = dig_q + DW'(1);
                end
            end
            ST_MAC: begin
                if (mac_c_q == N_M1) begin
                    mac_c_d = '0;
                    if (mac_r_q == N_M1) begin
                        mac_r_d    = '0;
                        state_d    = ST_EMIT;
                        start_emit = 1'b1;
                    end else begin
                        mac_r_d = mac_r_q + IW'(1);
                    end
                end else begin
                    mac_c_d = mac_c_q + IW'(1);
                end
            end
            ST_EMIT: if (emit_done) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // N parallel lanes: row mac_r_q of A against column mac_c_q of B.
    always_comb begin
        mac_sum = '0;
        for (int k = 0; k < N; k++) begin
            prod[k] = (2*EW)'(a_q[mac_r_q][k]) * (2*EW)'(b_q[k][mac_c_q]);
            mac_sum = mac_sum + ACCW'(prod[k]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            ld_row_q   <= '0;
            ld_col_q   <= '0;
            mac_r_q    <= '0;
            mac_c_q    <= '0;
            dig_q      <= '0;
            part_q     <= '0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_q[r][c] <= '0;
                    b_q[r][c] <= '0;
                    c_q[r][c] <= '0;
                end
            end
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == ST_LOAD_A) || (state_d == ST_LOAD_B);
            ld_row_q   <= ld_row_d;
            ld_col_q   <= ld_col_d;
            mac_r_q    <= mac_r_d;
            mac_c_q    <= mac_c_d;
            dig_q      <= dig_d;
            part_q     <= part_d;
            if (store_a) a_q[ld_row_q][ld_col_q] <= new_elem;
            if (store_b) b_q[ld_row_q][ld_col_q] <= new_elem;
            if (mac_en)  c_q[mac_r_q][mac_c_q]   <= mac_sum;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = (state_q inside {ST_LOAD_A, ST_LOAD_B, ST_MAC, ST_EMIT});
    assign done      = (state_q == ST_DONE);
    assign dbg_state = state_q;

    mat_ascii_fmt #(
        .N    (N),
        .ODIG (ODIG),
        .ACCW (ACCW)
    ) u_fmt (
        .clk        (clk),
        .reset      (reset),
        .start_emit (start_emit),
        .c_i        (c_q),
        .out_valid  (out_valid),
        .out_byte   (out_byte),
        .out_ready  (out_ready),
        .emit_done  (emit_done),
        .dbg_phase  (dbg_phase)
    );

endmodule

// File: tb/tb_mat_mult_stream.sv
// Directed bench for mat_mult_stream: a 4x4/2-digit instance and a
// 2x2/4-digit/8-output-digit instance sharing one set of driver tasks.
module tb_mat_mult_stream;
    import mat_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    // sel picks which instance the driver tasks talk to
    int         sel         = 0;
    logic       start_m     = 1'b0;
    logic       in_valid_m  = 1'b0;
    logic [7:0] in_byte_m   = 8'h00;
    logic       out_ready_m = 1'b0;

    logic       in_ready1, out_valid1, busy1, done1;
    logic [7:0] out_byte1;
    state_e     st1;
    phase_e     ph1;
    logic       in_ready2, out_valid2, busy2, done2;
    logic [7:0] out_byte2;
    state_e     st2;
    phase_e     ph2;

    logic       in_ready_m, out_valid_m, busy_m, done_m;
    logic [7:0] out_byte_m;
    assign in_ready_m  = (sel == 0) ? in_ready1  : in_ready2;
    assign out_valid_m = (sel == 0) ? out_valid1 : out_valid2;
    assign busy_m      = (sel == 0) ? busy1      : busy2;
    assign done_m      = (sel == 0) ? done1      : done2;
    assign out_byte_m  = (sel == 0) ? out_byte1  : out_byte2;

    mat_mult_stream #(.N(4), .DIGITS(2), .ODIG(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start_m && (sel == 0)),
        .in_valid  (in_valid_m && (sel == 0)),
        .in_byte   (in_byte_m),
        .in_ready  (in_ready1),
        .out_valid (out_valid1),
        .out_byte  (out_byte1),
        .out_ready (out_ready_m),
        .busy      (busy1),
        .done      (done1),
        .dbg_state (st1),
        .dbg_phase (ph1)
    );

    mat_mult_stream #(.N(2), .DIGITS(4), .ODIG(8)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .start     (start_m && (sel == 1)),
        .in_valid  (in_valid_m && (sel == 1)),
        .in_byte   (in_byte_m),
        .in_ready  (in_ready2),
        .out_valid (out_valid2),
        .out_byte  (out_byte2),
        .out_ready (out_ready_m),
        .busy      (busy2),
        .done      (done2),
        .dbg_state (st2),
        .dbg_phase (ph2)
    );

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic string mk_exp(input int n, input string r0, input string r1,
                                     input string r2, input string r3);
        string s;
        string rr[4];
        rr[0] = r0; rr[1] = r1; rr[2] = r2; rr[3] = r3;
        s = {"The result is:", "\015\012"};
        for (int i = 0; i < n; i++) s = {s, "[ ", rr[i], " ]", "\015\012"};
        return {s, "\015\012"};
    endfunction

    // ---------------- driver tasks (entered and left at posedge+1) ----------------
    task automatic start_job(input string tag);
        start_m = 1'b1;
        @(posedge clk); #1;
        start_m = 1'b0;
        check_eq({tag, " busy_after_start"}, busy_m, 1);
        check_eq({tag, " in_ready_load"}, in_ready_m, 1);
    endtask

    task automatic send_str(input string s, output int stalls);
        int i = 0;
        int guard = 0;
        stalls = 0;
        while (i < s.len() && guard < 4000) begin
            in_valid_m = 1'b1;
            in_byte_m  = s[i];
            @(negedge clk);
            guard++;
            if (in_ready_m) i++;
            else            stalls++;
            @(posedge clk); #1;
        end
        in_valid_m = 1'b0;
        check_eq("send_complete", i, s.len());
    endtask

    task automatic collect(input string tag, input string exp, input bit stall, output int n_rx);
        int cyc = 0;
        int dones = 0;
        bit pend = 1'b0;
        logic [7:0] pend_byte = 8'h00;
        logic [7:0] e;
        n_rx = 0;
        exp_q.delete();
        for (int i = 0; i < exp.len(); i++) exp_q.push_back(exp[i]);
        while (dones == 0 && cyc < 3000) begin
            out_ready_m = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            cyc++;
            if (pend) begin
                check_eq({tag, " hold_valid"}, out_valid_m, 1);
                check_eq({tag, " hold_byte"}, out_byte_m, pend_byte);
            end
            if (done_m) begin
                dones++;
                check_eq({tag, " busy_at_done"}, busy_m, 0);
                check_eq({tag, " valid_at_done"}, out_valid_m, 0);
            end else if (out_valid_m && out_ready_m) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq($sformatf("%s byte%0d", tag, n_rx), out_byte_m, e);
                end
                n_rx++;
            end
            pend      = out_valid_m && !out_ready_m;
            pend_byte = out_byte_m;
            @(posedge clk); #1;
        end
        out_ready_m = 1'b0;
        check_eq({tag, " done_seen"}, dones, 1);
        @(negedge clk);
        check_eq({tag, " done_single"}, done_m, 0);
        @(posedge clk); #1;
    endtask

    task automatic run_job(input string tag, input string a, input string b, input bit stall,
                           input string exp, input int exp_len);
        int stalls;
        int n_rx;
        start_job(tag);
        send_str({a, b}, stalls);
        check_eq({tag, " in_stalls"}, stalls, 0);
        collect(tag, exp, stall, n_rx);
        check_eq({tag, " nbytes"}, n_rx, exp_len);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, " in_ready"}, in_ready_m, 0);
        check_eq({tag, " out_valid"}, out_valid_m, 0);
        check_eq({tag, " out_byte"}, out_byte_m, 0);
        check_eq({tag, " busy"}, busy_m, 0);
        check_eq({tag, " done"}, done_m, 0);
    endtask

    // ---------------- stimulus ----------------
    string a_id, b_seq, a_noisy, b_noisy, ff8, ff32;
    string exp_id, exp_ff, exp_n2;
    int    stalls_tmp;

    initial begin
        a_id    = "01000000000100000000010000000001";
        b_seq   = "0102030405060708090A0B0C0D0E0F10";
        a_noisy = " 01 00 00 00, 00 01 00 00, 00 00 01 00, 00 00 00 01";
        b_noisy = ", 01,02,03,04,05,06,07,08,09,0 a, 0b,0c,0d,0e,0f,1 0";
        ff8     = "FFFFFFFF";
        ff32    = {ff8, ff8, ff8, ff8};
        exp_id  = mk_exp(4, "0001, 0005, 0009, 000D", "0002, 0006, 000A, 000E",
                            "0003, 0007, 000B, 000F", "0004, 0008, 000C, 0010");
        exp_ff  = mk_exp(4, "F804, F804, F804, F804", "F804, F804, F804, F804",
                            "F804, F804, F804, F804", "F804, F804, F804, F804");
        exp_n2  = mk_exp(2, "00001234, 00000000", "00000000, 00000001", "", "");

        repeat (3) @(posedge clk);
        #1;
        sel = 0;
        check_reset_vals("rst0_a");
        check_eq("rst0_a state", st1, ST_IDLE);
        sel = 1;
        check_reset_vals("rst0_b");
        reset = 1'b1;
        @(posedge clk); #1;
        sel = 0;
        check_eq("idle in_ready", in_ready_m, 0);

        run_job("ident", a_id, b_seq, 1'b0, exp_id, 130);
        run_job("noisy", a_noisy, b_noisy, 1'b0, exp_id, 130);
        run_job("stall", a_id, b_seq, 1'b1, exp_id, 130);

        // abort in the middle of B with a partially shifted element pending
        start_job("abort");
        send_str({a_id, "0102030405", "0"}, stalls_tmp);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("abort");
        check_eq("abort state", st1, ST_IDLE);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        run_job("allff", ff32, ff32, 1'b0, exp_ff, 130);

        sel = 1;
        run_job("n2", "1234000000000001", "0001000000000001", 1'b0, exp_n2, 66);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
